// File: rtl/core_response_interface_if.sv
// Cache-controller -> LDST update return path bundle.
// slave = response interface block, master = cache controller plus LDST environment.
interface core_response_interface_if #(
   parameter int unsigned THREAD_NUMB = 8,
   parameter int unsigned SIZE        = 8,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LINE_W      = 512
);
   localparam int unsigned TID_W = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1;
   localparam int unsigned OCC_W = $clog2(SIZE + 1);

   logic                   cc_update_valid;
   logic [1:0]             cc_update_command;
   logic [TID_W-1:0]       cc_update_thread_id;
   logic                   cc_update_wakeup;
   logic [ADDR_W-1:0]      cc_update_address;
   logic [1:0]             cc_update_privileges;
   logic [LINE_W-1:0]      cc_update_cache_line;

   logic                   ci_update_fifo_available;
   logic                   ci_overflow_error;
   logic [OCC_W-1:0]       ci_update_occupancy;

   logic                   ci_ldst_update_valid;
   logic [1:0]             ci_ldst_update_command;
   logic [TID_W-1:0]       ci_ldst_update_thread_id;
   logic [ADDR_W-1:0]      ci_ldst_update_address;
   logic [1:0]             ci_ldst_update_privileges;
   logic [LINE_W-1:0]      ci_ldst_update_cache_line;
   logic                   ldst_update_ready;

   logic                   ci_ldst_wakeup_valid;
   logic [THREAD_NUMB-1:0] ci_ldst_wakeup_thread_mask;

   modport master (
      output cc_update_valid, cc_update_command, cc_update_thread_id, cc_update_wakeup,
             cc_update_address, cc_update_privileges, cc_update_cache_line, ldst_update_ready,
      input  ci_update_fifo_available, ci_overflow_error, ci_update_occupancy,
             ci_ldst_update_valid, ci_ldst_update_command, ci_ldst_update_thread_id,
             ci_ldst_update_address, ci_ldst_update_privileges, ci_ldst_update_cache_line,
             ci_ldst_wakeup_valid, ci_ldst_wakeup_thread_mask
   );

   modport slave (
      input  cc_update_valid, cc_update_command, cc_update_thread_id, cc_update_wakeup,
             cc_update_address, cc_update_privileges, cc_update_cache_line, ldst_update_ready,
      output ci_update_fifo_available, ci_overflow_error, ci_update_occupancy,
             ci_ldst_update_valid, ci_ldst_update_command, ci_ldst_update_thread_id,
             ci_ldst_update_address, ci_ldst_update_privileges, ci_ldst_update_cache_line,
             ci_ldst_wakeup_valid, ci_ldst_wakeup_thread_mask
   );
endinterface

// File: rtl/core_response_interface.sv
// In-order update FIFO from cache controller to LDST with registered head stage
// and a one-cycle thread wake-up pulse after each delivered wake-up command.
module core_response_interface #(
   parameter int unsigned THREAD_NUMB           = 8,
   parameter int unsigned SIZE                  = 8,
   parameter int unsigned ALMOST_FULL_THRESHOLD = SIZE - 2,
   parameter int unsigned ADDR_W                = 32,
   parameter int unsigned LINE_W                = 512
) (
   input logic                     clk,
   input logic                     reset,
   core_response_interface_if.slave bus
);
   localparam int unsigned TID_W = (THREAD_NUMB > 1) ? $clog2(THREAD_NUMB) : 1;
   localparam int unsigned PTR_W = $clog2(SIZE);
   localparam int unsigned OCC_W = $clog2(SIZE + 1);

   localparam logic [OCC_W-1:0] FULL_CNT   = OCC_W'(SIZE);
   localparam logic [OCC_W-1:0] ONE_CNT    = OCC_W'(1);
   localparam logic [OCC_W-1:0] THRESH_CNT = OCC_W'(ALMOST_FULL_THRESHOLD);

   typedef struct packed {
      logic [1:0]        command;
      logic [TID_W-1:0]  thread_id;
      logic              wakeup;
      logic [ADDR_W-1:0] address;
      logic [1:0]        privileges;
      logic [LINE_W-1:0] cache_line;
   } entry_t;

   // count_q covers the head register plus the entries parked behind it in mem_q
   entry_t                 mem_q [SIZE];
   entry_t                 head_q, head_d;
   entry_t                 in_entry;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]       count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   wake_valid_q, wake_valid_d;
   logic [THREAD_NUMB-1:0] wake_mask_q, wake_mask_d;

   logic head_valid;
   logic deq;
   logic enq;
   logic enq_to_head;
   logic refill_head;
   logic mem_we;

   always_comb begin
      in_entry            = '0;
      in_entry.command    = bus.cc_update_command;
      in_entry.thread_id  = bus.cc_update_thread_id;
      in_entry.wakeup     = bus.cc_update_wakeup;
      in_entry.address    = bus.cc_update_address;
      in_entry.privileges = bus.cc_update_privileges;
      in_entry.cache_line = bus.cc_update_cache_line;
   end

   always_comb begin
      head_valid   = (count_q != '0);
      deq          = head_valid & bus.ldst_update_ready;
      enq          = bus.cc_update_valid & ((count_q < FULL_CNT) | deq);
      // New entry bypasses storage when the head is (or is about to become) empty
      enq_to_head  = enq & ((count_q == '0) | (deq & (count_q == ONE_CNT)));
      refill_head  = deq & (count_q > ONE_CNT);
      mem_we       = enq & ~enq_to_head;

      head_d       = head_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      count_d      = count_q;
      overflow_d   = overflow_q;
      wake_valid_d = 1'b0;
      wake_mask_d  = '0;

      if (enq_to_head) begin
         head_d = in_entry;
      end else if (refill_head) begin
         head_d = mem_q[rd_ptr_q];
      end

      if (refill_head) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (mem_we) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      unique case ({enq, deq})
         2'b10:   count_d = count_q + ONE_CNT;
         2'b01:   count_d = count_q - ONE_CNT;
         default: count_d = count_q;
      endcase

      if (bus.cc_update_valid & ~enq) begin
         overflow_d = 1'b1;
      end

      if (deq & head_q.wakeup) begin
         wake_valid_d                    = 1'b1;
         wake_mask_d[head_q.thread_id]   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q       <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         overflow_q   <= 1'b0;
         wake_valid_q <= 1'b0;
         wake_mask_q  <= '0;
      end else begin
         head_q       <= head_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         overflow_q   <= overflow_d;
         wake_valid_q <= wake_valid_d;
         wake_mask_q  <= wake_mask_d;
      end
   end

   // Payload storage needs no reset: count_q alone decides what is live
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   assign bus.ci_update_fifo_available   = (count_q < THRESH_CNT);
   assign bus.ci_overflow_error          = overflow_q;
   assign bus.ci_update_occupancy        = count_q;

   assign bus.ci_ldst_update_valid       = head_valid;
   assign bus.ci_ldst_update_command     = head_q.command;
   assign bus.ci_ldst_update_thread_id   = head_q.thread_id;
   assign bus.ci_ldst_update_address     = head_q.address;
   assign bus.ci_ldst_update_privileges  = head_q.privileges;
   assign bus.ci_ldst_update_cache_line  = head_q.cache_line;

   assign bus.ci_ldst_wakeup_valid       = wake_valid_q;
   assign bus.ci_ldst_wakeup_thread_mask = wake_mask_q;

   property p_count_bounded;
      @(posedge clk) disable iff (!reset) count_q <= FULL_CNT;
   endproperty
   a_count_bounded: assert property (p_count_bounded);

   property p_pulse_one_hot;
      @(posedge clk) disable iff (!reset) wake_valid_q |-> $onehot(wake_mask_q);
   endproperty
   a_pulse_one_hot: assert property (p_pulse_one_hot);

endmodule

// File: tb/tb_core_response_interface.sv
// Directed bench for core_response_interface: queue-level reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_core_response_interface;
   localparam int unsigned NT   = 8;
   localparam int unsigned SZ   = 8;
   localparam int unsigned AW   = 32;
   localparam int unsigned LW   = 512;
   localparam int unsigned THR  = SZ - 2;

   logic clk;
   logic reset;
   int   errs;
   int   checks;

   core_response_interface_if #(.THREAD_NUMB(NT), .SIZE(SZ), .ADDR_W(AW), .LINE_W(LW)) bus ();

   core_response_interface #(
      .THREAD_NUMB(NT), .SIZE(SZ), .ALMOST_FULL_THRESHOLD(THR), .ADDR_W(AW), .LINE_W(LW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]    cmd;
      logic [2:0]    tid;
      logic          wk;
      logic [AW-1:0] addr;
      logic [1:0]    priv;
      logic [LW-1:0] line;
   } ent_t;

   ent_t       mq[$];
   bit         m_ovf;
   bit         m_wv;
   logic [7:0] m_wm;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [LW-1:0] line_pat(input int unsigned k);
      logic [31:0] w;
      w = 32'hA5A5_0000 + k;
      return {16{w}};
   endfunction

   // Reference model: a plain queue, updated at each accepting edge
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_ovf = 1'b0;
         m_wv  = 1'b0;
         m_wm  = '0;
      end else begin
         bit d, e;
         ent_t n;
         d = (mq.size() > 0) && bus.ldst_update_ready;
         e = bus.cc_update_valid && ((mq.size() < SZ) || d);
         m_wv = d && mq[0].wk;
         m_wm = m_wv ? (8'd1 << mq[0].tid) : 8'd0;
         if (d) void'(mq.pop_front());
         if (e) begin
            n.cmd  = bus.cc_update_command;
            n.tid  = bus.cc_update_thread_id;
            n.wk   = bus.cc_update_wakeup;
            n.addr = bus.cc_update_address;
            n.priv = bus.cc_update_privileges;
            n.line = bus.cc_update_cache_line;
            mq.push_back(n);
         end
         if (bus.cc_update_valid && !e) m_ovf = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("m_valid", LW'(bus.ci_ldst_update_valid), LW'(mq.size() != 0));
         chk("m_occ", LW'(bus.ci_update_occupancy), LW'(mq.size()));
         chk("m_avail", LW'(bus.ci_update_fifo_available), LW'(mq.size() < THR));
         chk("m_ovf", LW'(bus.ci_overflow_error), LW'(m_ovf));
         chk("m_wake", LW'(bus.ci_ldst_wakeup_valid), LW'(m_wv));
         chk("m_mask", LW'(bus.ci_ldst_wakeup_thread_mask), LW'(m_wm));
         if (mq.size() != 0) begin
            chk("m_cmd", LW'(bus.ci_ldst_update_command), LW'(mq[0].cmd));
            chk("m_tid", LW'(bus.ci_ldst_update_thread_id), LW'(mq[0].tid));
            chk("m_addr", LW'(bus.ci_ldst_update_address), LW'(mq[0].addr));
            chk("m_priv", LW'(bus.ci_ldst_update_privileges), LW'(mq[0].priv));
            chk("m_line", bus.ci_ldst_update_cache_line, mq[0].line);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] cmd, input logic [2:0] tid, input logic wk,
                        input logic [AW-1:0] addr, input logic [1:0] priv, input logic [LW-1:0] line);
      bus.cc_update_valid      = 1'b1;
      bus.cc_update_command    = cmd;
      bus.cc_update_thread_id  = tid;
      bus.cc_update_wakeup     = wk;
      bus.cc_update_address    = addr;
      bus.cc_update_privileges = priv;
      bus.cc_update_cache_line = line;
   endtask

   task automatic idle();
      bus.cc_update_valid = 1'b0;
   endtask

   initial begin
      int sent;
      errs   = 0;
      checks = 0;
      reset  = 1'b0;
      bus.cc_update_valid      = 1'b0;
      bus.cc_update_command    = '0;
      bus.cc_update_thread_id  = '0;
      bus.cc_update_wakeup     = 1'b0;
      bus.cc_update_address    = '0;
      bus.cc_update_privileges = '0;
      bus.cc_update_cache_line = '0;
      bus.ldst_update_ready    = 1'b0;

      repeat (2) cyc();
      chk("rst_valid", LW'(bus.ci_ldst_update_valid), LW'(0));
      chk("rst_occ", LW'(bus.ci_update_occupancy), LW'(0));
      chk("rst_avail", LW'(bus.ci_update_fifo_available), LW'(1));
      chk("rst_ovf", LW'(bus.ci_overflow_error), LW'(0));
      chk("rst_wake", LW'(bus.ci_ldst_wakeup_valid), LW'(0));
      reset = 1'b1;
      cyc();

      // Single refill with wake-up
      bus.ldst_update_ready = 1'b1;
      drive(2'd1, 3'd3, 1'b1, 32'h1240, 2'b11, line_pat(1));
      cyc();
      idle();
      chk("ref_valid", LW'(bus.ci_ldst_update_valid), LW'(1));
      chk("ref_addr", LW'(bus.ci_ldst_update_address), LW'(32'h1240));
      chk("ref_tid", LW'(bus.ci_ldst_update_thread_id), LW'(3));
      chk("ref_cmd", LW'(bus.ci_ldst_update_command), LW'(1));
      chk("ref_line", bus.ci_ldst_update_cache_line, line_pat(1));
      chk("ref_nowake_yet", LW'(bus.ci_ldst_wakeup_valid), LW'(0));
      cyc();
      chk("ref_wake", LW'(bus.ci_ldst_wakeup_valid), LW'(1));
      chk("ref_mask", LW'(bus.ci_ldst_wakeup_thread_mask), LW'(8'h08));
      cyc();
      chk("ref_wake_end", LW'(bus.ci_ldst_wakeup_valid), LW'(0));
      chk("ref_mask_end", LW'(bus.ci_ldst_wakeup_thread_mask), LW'(0));

      // Backpressure and ordering
      bus.ldst_update_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(2'd0, 3'(i), 1'b0, 32'(i * 16), 2'b01, line_pat(10 + i));
         cyc();
      end
      idle();
      chk("bp_occ", LW'(bus.ci_update_occupancy), LW'(5));
      chk("bp_avail", LW'(bus.ci_update_fifo_available), LW'(1));
      cyc();
      chk("bp_stable", LW'(bus.ci_ldst_update_address), LW'(0));
      bus.ldst_update_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_order", LW'(bus.ci_ldst_update_address), LW'(i * 16));
         cyc();
      end
      chk("bp_empty", LW'(bus.ci_ldst_update_valid), LW'(0));

      // Commands without wake-up
      drive(2'd2, 3'd5, 1'b0, 32'h3000, 2'b00, line_pat(20));
      cyc();
      drive(2'd3, 3'd6, 1'b0, 32'h3040, 2'b10, line_pat(21));
      cyc();
      idle();
      chk("nw_cmd", LW'(bus.ci_ldst_update_command), LW'(3));
      chk("nw_wake0", LW'(bus.ci_ldst_wakeup_valid), LW'(0));
      cyc();
      chk("nw_wake1", LW'(bus.ci_ldst_wakeup_valid), LW'(0));
      chk("nw_mask", LW'(bus.ci_ldst_wakeup_thread_mask), LW'(0));
      chk("nw_empty", LW'(bus.ci_ldst_update_valid), LW'(0));

      // Random traffic through pointer wrap
      sent = 0;
      for (int c = 0; c < 400 && sent < 20; c++) begin
         bus.ldst_update_ready = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1) == 1 && mq.size() < SZ) begin
            drive(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  $urandom(), 2'($urandom_range(0, 3)), line_pat($urandom_range(0, 999)));
            sent++;
         end else begin
            idle();
         end
         cyc();
         chk("rnd_occ_max", LW'(bus.ci_update_occupancy <= SZ), LW'(1));
      end
      idle();
      chk("rnd_sent", LW'(sent), LW'(20));
      bus.ldst_update_ready = 1'b1;
      for (int c = 0; c < 20 && bus.ci_ldst_update_valid; c++) cyc();
      chk("rnd_drained", LW'(bus.ci_update_occupancy), LW'(0));

      // Full boundary
      bus.ldst_update_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(2'd1, 3'(i), 1'(i % 2), 32'h800 + 32'(i * 16), 2'b11, line_pat(30 + i));
         cyc();
      end
      idle();
      chk("full_occ", LW'(bus.ci_update_occupancy), LW'(8));
      chk("full_avail", LW'(bus.ci_update_fifo_available), LW'(0));
      chk("full_ovf0", LW'(bus.ci_overflow_error), LW'(0));
      bus.ldst_update_ready = 1'b1;
      drive(2'd0, 3'd7, 1'b0, 32'h900, 2'b01, line_pat(40));
      cyc();
      chk("full_sim_occ", LW'(bus.ci_update_occupancy), LW'(8));
      chk("full_sim_ovf", LW'(bus.ci_overflow_error), LW'(0));
      chk("full_sim_head", LW'(bus.ci_ldst_update_address), LW'(32'h810));
      bus.ldst_update_ready = 1'b0;
      drive(2'd0, 3'd7, 1'b0, 32'hA00, 2'b01, line_pat(41));
      cyc();
      idle();
      chk("ovf_set", LW'(bus.ci_overflow_error), LW'(1));
      chk("ovf_occ", LW'(bus.ci_update_occupancy), LW'(8));
      cyc();
      chk("ovf_sticky", LW'(bus.ci_overflow_error), LW'(1));
      bus.ldst_update_ready = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      chk("full_drained", LW'(bus.ci_update_occupancy), LW'(0));
      chk("ovf_still", LW'(bus.ci_overflow_error), LW'(1));

      // Reset mid-stream with entries queued and a wake-up pulse pending
      bus.ldst_update_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(2'd1, 3'(i + 1), 1'b1, 32'h500 + 32'(i * 16), 2'b11, line_pat(50 + i));
         cyc();
      end
      idle();
      bus.ldst_update_ready = 1'b1;
      cyc();
      chk("mr_pulse", LW'(bus.ci_ldst_wakeup_valid), LW'(1));
      #1 reset = 1'b0;
      #1;
      chk("mr_valid", LW'(bus.ci_ldst_update_valid), LW'(0));
      chk("mr_occ", LW'(bus.ci_update_occupancy), LW'(0));
      chk("mr_avail", LW'(bus.ci_update_fifo_available), LW'(1));
      chk("mr_ovf", LW'(bus.ci_overflow_error), LW'(0));
      chk("mr_wake", LW'(bus.ci_ldst_wakeup_valid), LW'(0));
      chk("mr_mask", LW'(bus.ci_ldst_wakeup_thread_mask), LW'(0));
      chk("mr_addr", LW'(bus.ci_ldst_update_address), LW'(0));
      @(posedge clk);
      #1 reset = 1'b1;
      cyc();
      chk("post_occ", LW'(bus.ci_update_occupancy), LW'(0));
      chk("post_avail", LW'(bus.ci_update_fifo_available), LW'(1));
      chk("post_valid", LW'(bus.ci_ldst_update_valid), LW'(0));
      cyc();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
